battle_border_sprite: RTL and testbench

- Draws the white rectangular battle-box outline on the 640x480 VGA raster.
- Publishes the box's interior bounds so the player and bullet sprites can clamp and spawn inside it.
- The box animates between a wide dialog box and a small square battle box, according to the 2-bit game state.
- Sits between the VGA controller (which supplies x, y) and the pixel colour mux in the top level.

---
 rtl/game_pkg.sv | 26 ++
 rtl/battle_border_sprite_bound_stepper.sv | 37 +++
 rtl/battle_border_sprite.sv | 99 +++++++++
 tb/tb_battle_border_sprite.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants: state encoding, screen size and battle-box bounds.
package game_pkg;

  typedef enum logic [1:0] {
    ST_DIALOG = 2'b00,
    ST_BATTLE = 2'b01,
    ST_MENU   = 2'b10,
    ST_HIDDEN = 2'b11
  } game_state_t;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  // Interior bounds (inclusive) of the wide dialog box.
  localparam logic [9:0] DLG_L = 10'd32;
  localparam logic [9:0] DLG_R = 10'd607;
  localparam logic [9:0] DLG_T = 10'd250;
  localparam logic [9:0] DLG_B = 10'd399;

  // Interior bounds (inclusive) of the square battle box.
  localparam logic [9:0] BAT_L = 10'd240;
  localparam logic [9:0] BAT_R = 10'd400;
  localparam logic [9:0] BAT_T = 10'd240;
  localparam logic [9:0] BAT_B = 10'd400;

endpackage

// File: rtl/battle_border_sprite_bound_stepper.sv
// One animated bound: steps toward its target by at most STEP on each tick.
module bound_stepper #(
  parameter logic [9:0]  RESET_VAL = '0,
  parameter int unsigned STEP      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [9:0] target,
  output logic [9:0] cur,
  output logic       at_target
);

  localparam logic [9:0] STEP_V = 10'(STEP);

  logic [9:0] nxt;

  // Clamped step toward the target; never overshoots.
  always_comb begin
    nxt = cur;
    if (cur < target)
      nxt = ((target - cur) > STEP_V) ? cur + STEP_V : target;
    else if (cur > target)
      nxt = ((cur - target) > STEP_V) ? cur - STEP_V : target;
  end

  // Bound register, updated only on the frame tick.
  always_ff @(posedge clk) begin
    if (reset)
      cur <= RESET_VAL;
    else if (tick)
      cur <= nxt;
  end

  assign at_target = (cur == target);

endmodule

// File: rtl/battle_border_sprite.sv
// Battle-box outline sprite with per-frame animated interior bounds.
module battle_border_sprite
  import game_pkg::*;
#(
  parameter int unsigned BORDER_W = 5,
  parameter int unsigned STEP     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [1:0] state,
  output logic       border_on,
  output logic [9:0] left_border,
  output logic [9:0] right_border,
  output logic [9:0] top_border,
  output logic [9:0] bottom_border,
  output logic       settled
);

  localparam logic [10:0] BW      = 11'(BORDER_W);
  localparam logic [9:0]  V_LINE  = 10'(V_ACTIVE);

  game_state_t st;
  logic [9:0]  prev_y;
  logic        tick;
  logic [9:0]  tgt_l, tgt_r, tgt_t, tgt_b;
  logic        eq_l, eq_r, eq_t, eq_b;
  logic [10:0] x_w, y_w;
  logic        outer, inner;

  assign st = game_state_t'(state);

  // Target bounds follow the game state; only battle uses the small box.
  always_comb begin
    tgt_l = DLG_L;
    tgt_r = DLG_R;
    tgt_t = DLG_T;
    tgt_b = DLG_B;
    if (st == ST_BATTLE) begin
      tgt_l = BAT_L;
      tgt_r = BAT_R;
      tgt_t = BAT_T;
      tgt_b = BAT_B;
    end
  end

  // Previous row, for the once-per-frame edge detect.
  always_ff @(posedge clk) begin
    if (reset)
      prev_y <= '0;
    else
      prev_y <= y;
  end

  assign tick = (y == V_LINE) && (prev_y != V_LINE);

  bound_stepper #(.RESET_VAL(DLG_L), .STEP(STEP)) u_left (
    .clk(clk), .reset(reset), .tick(tick), .target(tgt_l),
    .cur(left_border), .at_target(eq_l)
  );

  bound_stepper #(.RESET_VAL(DLG_R), .STEP(STEP)) u_right (
    .clk(clk), .reset(reset), .tick(tick), .target(tgt_r),
    .cur(right_border), .at_target(eq_r)
  );

  bound_stepper #(.RESET_VAL(DLG_T), .STEP(STEP)) u_top (
    .clk(clk), .reset(reset), .tick(tick), .target(tgt_t),
    .cur(top_border), .at_target(eq_t)
  );

  bound_stepper #(.RESET_VAL(DLG_B), .STEP(STEP)) u_bottom (
    .clk(clk), .reset(reset), .tick(tick), .target(tgt_b),
    .cur(bottom_border), .at_target(eq_b)
  );

  // Outline hit test, widened to 11 bits so R+BORDER_W cannot wrap.
  always_comb begin
    x_w   = {1'b0, x};
    y_w   = {1'b0, y};
    outer = (x_w >= {1'b0, left_border}  - BW) && (x_w <= {1'b0, right_border}  + BW) &&
            (y_w >= {1'b0, top_border}   - BW) && (y_w <= {1'b0, bottom_border} + BW);
    inner = (x_w >= {1'b0, left_border}) && (x_w <= {1'b0, right_border}) &&
            (y_w >= {1'b0, top_border})  && (y_w <= {1'b0, bottom_border});
  end

  // Registered pixel output and settled flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      border_on <= 1'b0;
      settled   <= 1'b1;
    end else begin
      border_on <= outer && !inner && (st != ST_HIDDEN);
      settled   <= eq_l && eq_r && eq_t && eq_b;
    end
  end

endmodule

// File: tb/tb_battle_border_sprite.sv
module tb_battle_border_sprite;

  logic       clk;
  logic       reset;
  logic [9:0] x;
  logic [9:0] y;
  logic [1:0] state;
  logic       border_on;
  logic [9:0] left_border, right_border, top_border, bottom_border;
  logic       settled;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic       b;
    logic [9:0] l, r, t, bo;
    logic       s;
  } exp_t;

  exp_t sb[$];

  // reference model state
  int m_l, m_r, m_t, m_b;
  int m_prev_y;

  battle_border_sprite #(.BORDER_W(5), .STEP(8)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .state(state),
    .border_on(border_on), .left_border(left_border), .right_border(right_border),
    .top_border(top_border), .bottom_border(bottom_border), .settled(settled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int mv(input int cur, input int tgt);
    if (tgt > cur) return (tgt - cur > 8) ? cur + 8 : tgt;
    if (tgt < cur) return (cur - tgt > 8) ? cur - 8 : tgt;
    return cur;
  endfunction

  // One clock: predict from current inputs, push, clock, pop and compare.
  task automatic step(input string tag);
    exp_t e;
    int tl, tr, tt, tb;
    bit outer, inner, tk;
    if (state == 2'b01) begin tl = 240; tr = 400; tt = 240; tb = 400; end
    else                begin tl = 32;  tr = 607; tt = 250; tb = 399; end
    e.tag = tag;
    if (reset) begin
      m_l = 32; m_r = 607; m_t = 250; m_b = 399; m_prev_y = 0;
      e.b = 1'b0; e.s = 1'b1;
    end else begin
      outer = (int'(x) >= m_l - 5) && (int'(x) <= m_r + 5) &&
              (int'(y) >= m_t - 5) && (int'(y) <= m_b + 5);
      inner = (int'(x) >= m_l) && (int'(x) <= m_r) && (int'(y) >= m_t) && (int'(y) <= m_b);
      e.b = outer && !inner && (state != 2'b11);
      e.s = (m_l == tl) && (m_r == tr) && (m_t == tt) && (m_b == tb);
      tk = (int'(y) == 480) && (m_prev_y != 480);
      if (tk) begin
        m_l = mv(m_l, tl); m_r = mv(m_r, tr); m_t = mv(m_t, tt); m_b = mv(m_b, tb);
      end
      m_prev_y = int'(y);
    end
    e.l = 10'(m_l); e.r = 10'(m_r); e.t = 10'(m_t); e.bo = 10'(m_b);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".border_on"}, {10'd0, border_on}, {10'd0, e.b});
    chk({e.tag, ".left"},      {1'b0, left_border},   {1'b0, e.l});
    chk({e.tag, ".right"},     {1'b0, right_border},  {1'b0, e.r});
    chk({e.tag, ".top"},       {1'b0, top_border},    {1'b0, e.t});
    chk({e.tag, ".bottom"},    {1'b0, bottom_border}, {1'b0, e.bo});
    chk({e.tag, ".settled"},   {10'd0, settled},      {10'd0, e.s});
  endtask

  task automatic pix(input string tag, input int px, input int py);
    x = 10'(px); y = 10'(py);
    step(tag);
  endtask

  // One frame boundary: y=479, then y=480 held for several clocks, then back to 0.
  task automatic frame(input string tag);
    x = 10'd0;
    y = 10'd479; step(tag);
    y = 10'd480; step(tag); step(tag); step(tag);
    y = 10'd0;   step(tag);
  endtask

  initial begin
    reset = 1'b1; state = 2'b00; x = '0; y = '0;
    step("rst"); step("rst");
    chk("rst_left", {1'b0, left_border}, 11'd32);
    chk("rst_settled", {10'd0, settled}, 11'd1);
    reset = 1'b0;

    // dialog box edges
    pix("dlg_x30",  30,  300);
    chk("dlg_x30_const", {10'd0, border_on}, 11'd1);
    pix("dlg_x100", 100, 300);
    pix("dlg_x26",  26,  300);
    chk("dlg_x26_const", {10'd0, border_on}, 11'd0);

    // animate to battle
    state = 2'b01;
    frame("bat1");
    chk("bat1_left",   {1'b0, left_border},   11'd40);
    chk("bat1_right",  {1'b0, right_border},  11'd599);
    chk("bat1_top",    {1'b0, top_border},    11'd242);
    chk("bat1_bottom", {1'b0, bottom_border}, 11'd400);
    for (int unsigned i = 1; i < 26; i++) frame("bat");
    chk("bat26_left",  {1'b0, left_border},  11'd240);
    chk("bat26_right", {1'b0, right_border}, 11'd400);
    pix("bat_settle", 0, 0);
    chk("bat26_settled", {10'd0, settled}, 11'd1);

    // battle edge exactness
    for (int px = 235; px <= 240; px++) pix("bat_edge_l", px, 300);
    pix("bat_x405", 405, 300);
    chk("bat_x405_const", {10'd0, border_on}, 11'd1);
    pix("bat_x406", 406, 300);
    pix("bat_y234", 300, 234);
    pix("bat_y235", 300, 235);
    chk("bat_y235_const", {10'd0, border_on}, 11'd1);

    // tick uniqueness: retarget to dialog, hold y=480 for 800 clocks
    state = 2'b00;
    x = '0; y = 10'd479; step("hold");
    y = 10'd480;
    for (int unsigned i = 0; i < 800; i++) step("hold");
    chk("hold_left", {1'b0, left_border}, 11'd232);
    y = 10'd479; step("tog"); y = 10'd480; step("tog");
    y = 10'd479; step("tog"); y = 10'd480; step("tog");
    chk("tog_left", {1'b0, left_border}, 11'd216);

    // mid-animation retarget from a fresh reset
    reset = 1'b1; y = '0; step("rst2"); reset = 1'b0;
    state = 2'b01;
    for (int unsigned i = 0; i < 5; i++) frame("ret_bat");
    chk("ret_left72", {1'b0, left_border}, 11'd72);
    state = 2'b00;
    frame("ret_dlg");
    chk("ret_left64", {1'b0, left_border}, 11'd64);
    for (int unsigned i = 0; i < 5; i++) frame("ret_dlg");
    chk("ret_left32", {1'b0, left_border}, 11'd32);
    pix("ret_settle", 0, 0);

    // hidden: outline suppressed while bounds still move
    state = 2'b01;
    frame("hid_pre"); frame("hid_pre");
    state = 2'b11;
    for (int px = 20; px < 80; px += 3) pix("hid_row", px, 300);
    pix("hid_top", 300, 240);
    frame("hid_move");
    chk("hid_left", {1'b0, left_border}, 11'd40);
    pix("hid_pix", 36, 300);
    chk("hid_pix_const", {10'd0, border_on}, 11'd0);

    // reset during motion snaps to dialog bounds
    state = 2'b01;
    frame("mv"); frame("mv");
    reset = 1'b1; step("rst3");
    chk("rst3_left",   {1'b0, left_border},   11'd32);
    chk("rst3_right",  {1'b0, right_border},  11'd607);
    chk("rst3_top",    {1'b0, top_border},    11'd250);
    chk("rst3_bottom", {1'b0, bottom_border}, 11'd399);
    reset = 1'b0;
    pix("post_rst", 30, 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
